// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and source-select encoding for the writeback arbiter
package wb_pkg;
   localparam int WB_DATA_W     = 32;
   localparam int WB_DEST_W     = 5;
   localparam int WB_WADDR_W    = 16;
   localparam int WB_DEPTH      = 2;
   localparam int WB_STARVE_MAX = 4;
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ALU  = 2'd1,
      SRC_MEM  = 2'd2
   } src_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO with a separate occupancy counter
module wb_fifo
   import wb_pkg::*;
#(
   parameter int W = WB_DEST_W + WB_DATA_W,
   parameter int DEPTH = WB_DEPTH,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;
   assign dout  = mem[rd_ptr];
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and load results into one registered register-file write port
module writeback_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int DEST_W = WB_DEST_W,
   parameter int WADDR_W = WB_WADDR_W,
   parameter int DEPTH = WB_DEPTH,
   parameter int STARVE_MAX = WB_STARVE_MAX,
   parameter int R0_HARDWIRED = 1,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               alu_valid,
   output logic               alu_ready,
   input  logic [DEST_W-1:0]  alu_dest,
   input  logic [DATA_W-1:0]  alu_data,
   input  logic               mem_valid,
   output logic               mem_ready,
   input  logic [DEST_W-1:0]  mem_dest,
   input  logic [DATA_W-1:0]  mem_data,
   output logic               write_en,
   output logic [WADDR_W-1:0] write_address_0,
   output logic [DATA_W-1:0]  write_data,
   output logic [CW-1:0]      alu_count,
   output logic [CW-1:0]      mem_count
);
   localparam int EW = DEST_W + DATA_W;
   localparam int SW = $clog2(STARVE_MAX + 1);
   logic [EW-1:0]     alu_head, mem_head;
   logic              alu_full, alu_empty, mem_full, mem_empty;
   logic [DEST_W-1:0] gnt_dest;
   logic [DATA_W-1:0] gnt_data;
   logic [SW-1:0]     starve;
   src_t              sel;
   assign alu_ready = !alu_full;
   assign mem_ready = !mem_full;
   wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_alu (
      .clk(clk), .rst_n(rst_n), .push(alu_valid && alu_ready), .pop(sel == SRC_ALU),
      .din({alu_dest, alu_data}), .dout(alu_head), .full(alu_full), .empty(alu_empty),
      .count(alu_count)
   );
   wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_mem (
      .clk(clk), .rst_n(rst_n), .push(mem_valid && mem_ready), .pop(sel == SRC_MEM),
      .din({mem_dest, mem_data}), .dout(mem_head), .full(mem_full), .empty(mem_empty),
      .count(mem_count)
   );
   // MEM wins contention until ALU has waited STARVE_MAX grants
   always_comb begin
      sel = (!alu_empty && !mem_empty) ? (starve == SW'(STARVE_MAX) ? SRC_ALU : SRC_MEM)
          : !alu_empty ? SRC_ALU : !mem_empty ? SRC_MEM : SRC_NONE;
      gnt_dest = sel == SRC_ALU ? alu_head[EW-1:DATA_W] : mem_head[EW-1:DATA_W];
      gnt_data = sel == SRC_ALU ? alu_head[DATA_W-1:0] : mem_head[DATA_W-1:0];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) starve <= '0;
      else if (sel == SRC_ALU || alu_empty) starve <= '0;
      else if (sel == SRC_MEM && starve != SW'(STARVE_MAX)) starve <= starve + SW'(1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         write_en        <= 1'b0;
         write_address_0 <= '0;
         write_data      <= '0;
      end else begin
         write_en <= sel != SRC_NONE && !(R0_HARDWIRED != 0 && gnt_dest == '0);
         if (sel != SRC_NONE) begin
            write_address_0 <= WADDR_W'(gnt_dest);
            write_data      <= gnt_data;
         end
      end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: queue-model scoreboard plus directed writeback scenarios
module tb_writeback_arbiter;
   localparam int DEPTH = 2;
   localparam int SMAX = 4;
   typedef struct {
      logic [4:0]  d;
      logic [31:0] v;
   } ent_t;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        alu_valid = 1'b0, mem_valid = 1'b0;
   logic [4:0]  alu_dest = '0, mem_dest = '0;
   logic [31:0] alu_data = '0, mem_data = '0;
   logic        alu_ready, mem_ready, write_en;
   logic [15:0] write_address_0;
   logic [31:0] write_data;
   logic [1:0]  alu_count, mem_count;
   int checks = 0, errors = 0;
   ent_t aq[$], mq[$];
   ent_t e;
   int st, g;
   bit pa, pm;
   logic exp_en = 1'b0;
   logic [15:0] exp_addr = '0;
   logic [31:0] exp_data = '0;
   int grants[$];
   logic [47:0] wlog[$];
   int na, nm;
   bit ra, rm;

   writeback_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
      .write_en(write_en), .write_address_0(write_address_0), .write_data(write_data),
      .alu_count(alu_count), .mem_count(mem_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", n, a, x, $time);
      end
   endtask

   // Reference: one queue per source, grant chosen from queue heads each edge
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         aq.delete();
         mq.delete();
         st = 0;
         exp_en = 1'b0;
         exp_addr = '0;
         exp_data = '0;
      end else begin
         pa = alu_valid && aq.size() < DEPTH;
         pm = mem_valid && mq.size() < DEPTH;
         g = (aq.size() > 0 && mq.size() > 0) ? (st == SMAX ? 1 : 2)
           : aq.size() > 0 ? 1 : mq.size() > 0 ? 2 : 0;
         st = (g == 1 || aq.size() == 0) ? 0 : (st < SMAX ? st + 1 : st);
         exp_en = 1'b0;
         if (g != 0) begin
            e = (g == 1) ? aq.pop_front() : mq.pop_front();
            grants.push_back(g);
            exp_en = e.d != 0;
            exp_addr = {11'b0, e.d};
            exp_data = e.v;
         end
         if (pa) aq.push_back('{alu_dest, alu_data});
         if (pm) mq.push_back('{mem_dest, mem_data});
      end

   always @(negedge clk)
      if (rst_n) begin
         chk("write_en", write_en, exp_en);
         if (exp_en) begin
            chk("write_address_0", write_address_0, exp_addr);
            chk("write_data", write_data, exp_data);
         end
         chk("alu_ready", alu_ready, aq.size() < DEPTH);
         chk("mem_ready", mem_ready, mq.size() < DEPTH);
         chk("alu_count", alu_count, aq.size());
         chk("mem_count", mem_count, mq.size());
         if (write_en) wlog.push_back({write_address_0, write_data});
      end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_we", write_en, 0);
      chk("rst_addr", write_address_0, 0);
      chk("rst_data", write_data, 0);
      chk("rst_ready", {alu_ready, mem_ready}, 2'b11);
      chk("rst_counts", {alu_count, mem_count}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      // single ALU write, two edges to the strobe
      wlog.delete();
      alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'hDEADBEEF;
      @(negedge clk);
      alu_valid = 1'b0;
      chk("single_early", write_en, 0);
      @(negedge clk);
      chk("single_we", write_en, 1);
      chk("single_addr", write_address_0, 16'h0005);
      chk("single_data", write_data, 32'hDEADBEEF);
      @(negedge clk);
      chk("single_pulse", write_en, 0);
      chk("single_cnt", wlog.size(), 1);
      // three back-to-back ALU entries
      wlog.delete();
      for (int i = 1; i <= 3; i++) begin
         alu_valid = 1'b1; alu_dest = 5'(i); alu_data = 32'(100 + i);
         chk("bp_ready", alu_ready, 1);
         @(negedge clk);
      end
      alu_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("bp_cnt", wlog.size(), 3);
      for (int i = 0; i < 3 && i < wlog.size(); i++)
         chk("bp_order", wlog[i], {16'(i + 1), 32'(101 + i)});
      // sustained contention on both sources
      grants.delete(); wlog.delete();
      na = 0; nm = 0;
      for (int c = 0; c < 30; c++) begin
         alu_valid = 1'b1; alu_dest = 5'(8 + na % 8); alu_data = 32'hA000 + 32'(na);
         mem_valid = 1'b1; mem_dest = 5'(16 + nm % 8); mem_data = 32'hB000 + 32'(nm);
         ra = alu_ready; rm = mem_ready;
         @(negedge clk);
         if (ra) na++;
         if (rm) nm++;
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      repeat (8) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         chk("starve_model", k < grants.size() ? grants[k] : -1, (k % 5 == 4) ? 1 : 2);
         chk("starve_dut", k < wlog.size() ? 64'(wlog[k][36]) : 64'hF, (k % 5 == 4) ? 0 : 1);
      end
      // destination 0 is consumed without a write
      wlog.delete();
      mem_valid = 1'b1; mem_dest = 5'd0; mem_data = 32'h1;
      @(negedge clk);
      mem_valid = 1'b0;
      alu_valid = 1'b1; alu_dest = 5'd7; alu_data = 32'h77;
      chk("r0_mcnt1", mem_count, 1);
      @(negedge clk);
      alu_valid = 1'b0;
      chk("r0_we", write_en, 0);
      chk("r0_mcnt0", mem_count, 0);
      @(negedge clk);
      chk("r0_next_we", write_en, 1);
      chk("r0_next_addr", write_address_0, 16'h0007);
      repeat (2) @(negedge clk);
      chk("r0_cnt", wlog.size(), 1);
      // asynchronous reset with entries buffered
      alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'h33;
      mem_valid = 1'b1; mem_dest = 5'd4; mem_data = 32'h44;
      repeat (4) @(negedge clk);
      alu_valid = 1'b0; mem_valid = 1'b0;
      chk("mid_filled", alu_count != 0, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_we", write_en, 0);
      chk("mid_counts", {alu_count, mem_count}, 0);
      chk("mid_ready", {alu_ready, mem_ready}, 2'b11);
      @(negedge clk);
      rst_n = 1'b1;
      wlog.delete();
      repeat (6) @(negedge clk);
      chk("mid_nowrite", wlog.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
